// File: rtl/clock_pkg.sv
// clock_pkg: shared moduli and widths for the alarm-clock time and alarm registers
package clock_pkg;
  localparam int MOD_SEC  = 60;
  localparam int MOD_MIN  = 60;
  localparam int MOD_HR24 = 24;
  localparam int MOD_HR12 = 12;
  localparam int W_SEC    = 6;
  localparam int W_MIN    = 6;
  localparam int W_HR     = 5;
endpackage

// File: rtl/bin_to_bcd2.sv
// bin_to_bcd2: combinational binary (< 100) to two BCD digits
module bin_to_bcd2 #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin,
  output logic [3:0]       tens,
  output logic [3:0]       units
);
  assign tens  = 4'(32'(bin) / 32'd10);
  assign units = 4'(32'(bin) % 32'd10);
endmodule

// File: rtl/counter_mod_n.sv
// counter_mod_n: modulo-N up/down cascadable counter with wrap/saturate and registered BCD
module counter_mod_n
  import clock_pkg::*;
#(
  parameter int MODULUS = MOD_HR24,
  parameter int WIDTH   = W_HR,
  parameter int WRAP    = 1,
  parameter int RST_VAL = 0
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Enable,
  input  logic             LD,
  input  logic [WIDTH-1:0] IN,
  input  logic             Cnt,
  input  logic             Up,
  input  logic             Cin,
  output logic [WIDTH-1:0] COUNT,
  output logic [3:0]       BCD_T,
  output logic [3:0]       BCD_U,
  output logic             TC,
  output logic             CO,
  output logic             LD_ERR
);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST   = WIDTH'(RST_VAL);
  localparam logic [3:0]       RST_T = 4'(RST_VAL / 10);
  localparam logic [3:0]       RST_U = 4'(RST_VAL % 10);
  generate
    if (MODULUS < 2 || MODULUS > 100 || (2.0 ** WIDTH) < MODULUS || RST_VAL >= MODULUS || RST_VAL < 0) begin : g_bad_params
      $error("counter_mod_n: illegal MODULUS/WIDTH/RST_VAL");
    end
  endgenerate
  logic             load;
  logic             step;
  logic             term;
  logic             ld_ok;
  logic [WIDTH-1:0] nxt;
  logic [3:0]       nxt_t;
  logic [3:0]       nxt_u;
  // ld_ok compares at 32 bits so MODULUS == 2**WIDTH cannot alias to zero
  always_comb begin
    load  = Enable & LD;
    step  = Enable & Cnt & Cin & ~LD;
    term  = Up ? COUNT == TOP : COUNT == '0;
    ld_ok = 32'(IN) < 32'(MODULUS);
    TC    = step & term;
    nxt   = load ? (ld_ok ? IN : COUNT)
          : !step ? COUNT
          : term ? (WRAP == 0 ? COUNT : Up ? '0 : TOP)
          : Up ? COUNT + WIDTH'(1) : COUNT - WIDTH'(1);
  end
  bin_to_bcd2 #(.WIDTH(WIDTH)) u_bcd (.bin(nxt), .tens(nxt_t), .units(nxt_u));
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      COUNT  <= RST;
      BCD_T  <= RST_T;
      BCD_U  <= RST_U;
      CO     <= 1'b0;
      LD_ERR <= 1'b0;
    end else begin
      COUNT  <= nxt;
      BCD_T  <= nxt_t;
      BCD_U  <= nxt_u;
      CO     <= step & term & (WRAP != 0);
      LD_ERR <= load & ~ld_ok;
    end
  end
endmodule

// File: tb/tb_counter_mod_n.sv
// tb_counter_mod_n: directed and randomized checks of sec/min/hr cascade plus a saturating 12-counter
module tb_counter_mod_n;
  logic clk = 1'b0;
  logic clr;
  logic chain;
  logic en [4];
  logic ld [4];
  logic cn [4];
  logic up [4];
  logic [6:0] din [4];
  logic [6:0] cnt [4];
  logic [3:0] bt [4];
  logic [3:0] bu [4];
  logic tc [4];
  logic co [4];
  logic err [4];
  logic cin1, cin2;
  logic [5:0] c0, c1;
  logic [4:0] c2;
  logic [3:0] c3;
  int n_tests = 0;
  int n_fail = 0;
  int md [4] = '{60, 60, 24, 12};
  int w  [4] = '{6, 6, 5, 4};
  bit wr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int m_cnt [4];
  int m_co [4];
  int m_err [4];
  int p_cnt [4];
  int p_co [4];
  int p_err [4];
  bit e_tc [4];
  always #5 clk = ~clk;
  assign cin1 = chain ? tc[0] : 1'b1;
  assign cin2 = chain ? tc[1] : 1'b1;
  assign cnt[0] = {1'b0, c0};
  assign cnt[1] = {1'b0, c1};
  assign cnt[2] = {2'b0, c2};
  assign cnt[3] = {3'b0, c3};
  counter_mod_n #(.MODULUS(60), .WIDTH(6), .WRAP(1), .RST_VAL(0)) u_sec (
    .Clk(clk), .Clr(clr), .Enable(en[0]), .LD(ld[0]), .IN(din[0][5:0]), .Cnt(cn[0]), .Up(up[0]),
    .Cin(1'b1), .COUNT(c0), .BCD_T(bt[0]), .BCD_U(bu[0]), .TC(tc[0]), .CO(co[0]), .LD_ERR(err[0]));
  counter_mod_n #(.MODULUS(60), .WIDTH(6), .WRAP(1), .RST_VAL(0)) u_min (
    .Clk(clk), .Clr(clr), .Enable(en[1]), .LD(ld[1]), .IN(din[1][5:0]), .Cnt(cn[1]), .Up(up[1]),
    .Cin(cin1), .COUNT(c1), .BCD_T(bt[1]), .BCD_U(bu[1]), .TC(tc[1]), .CO(co[1]), .LD_ERR(err[1]));
  counter_mod_n #(.MODULUS(24), .WIDTH(5), .WRAP(1), .RST_VAL(0)) u_hr (
    .Clk(clk), .Clr(clr), .Enable(en[2]), .LD(ld[2]), .IN(din[2][4:0]), .Cnt(cn[2]), .Up(up[2]),
    .Cin(cin2), .COUNT(c2), .BCD_T(bt[2]), .BCD_U(bu[2]), .TC(tc[2]), .CO(co[2]), .LD_ERR(err[2]));
  counter_mod_n #(.MODULUS(12), .WIDTH(4), .WRAP(0), .RST_VAL(0)) u_sat (
    .Clk(clk), .Clr(clr), .Enable(en[3]), .LD(ld[3]), .IN(din[3][3:0]), .Cnt(cn[3]), .Up(up[3]),
    .Cin(1'b1), .COUNT(c3), .BCD_T(bt[3]), .BCD_U(bu[3]), .TC(tc[3]), .CO(co[3]), .LD_ERR(err[3]));
  task automatic idle();
    clr = 1'b1;
    chain = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b1;
      ld[i] = 1'b0;
      cn[i] = 1'b0;
      up[i] = 1'b1;
      din[i] = '0;
    end
  endtask
  // Reference: signed step then either modular fold or clamp
  task automatic predict();
    for (int i = 0; i < 4; i++) begin
      bit ci;
      int s;
      bit beyond;
      ci = (chain && (i == 1 || i == 2)) ? e_tc[i == 0 ? 0 : i - 1] : 1'b1;
      s = m_cnt[i] + (up[i] ? 1 : -1);
      beyond = s < 0 || s >= md[i];
      e_tc[i] = en[i] && cn[i] && ci && !ld[i] && beyond;
      p_cnt[i] = m_cnt[i];
      p_co[i] = 0;
      p_err[i] = 0;
      if (!clr) p_cnt[i] = 0;
      else if (en[i] && ld[i]) begin
        if (int'(din[i]) < md[i]) p_cnt[i] = int'(din[i]);
        else p_err[i] = 1;
      end else if (en[i] && cn[i] && ci) begin
        if (!beyond) p_cnt[i] = s;
        else if (wr[i]) begin
          p_cnt[i] = (s + md[i]) % md[i];
          p_co[i] = 1;
        end
      end
    end
  endtask
  task automatic commit();
    @(posedge clk);
    @(negedge clk);
    m_cnt = p_cnt;
    m_co = p_co;
    m_err = p_err;
  endtask
  task automatic step_cycle();
    #1 predict();
    commit();
  endtask
  task automatic test_reset();
    idle();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld[i] = 1'b1;
      cn[i] = 1'b1;
      din[i] = 7'd5;
    end
    step_cycle();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (cnt[i] !== 7'd0 || bt[i] !== 4'd0 || bu[i] !== 4'd0 || co[i] !== 1'b0 || err[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got cnt=%0d bcd=%0d%0d co=%b err=%b, want 0 00 0 0", i, cnt[i], bt[i], bu[i], co[i], err[i]);
      end
    end
    idle();
  endtask
  task automatic test_count_up();
    idle();
    cn[2] = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step_cycle();
      n_tests++;
      if (cnt[2] !== 7'((k + 1) % 24) || co[2] !== (k == 23)) begin
        n_fail++;
        $display("FAIL up24 step %0d: got cnt=%0d co=%b, want %0d %b", k, cnt[2], co[2], (k + 1) % 24, k == 23);
      end
      if (k == 22) begin
        n_tests++;
        if (bt[2] !== 4'd2 || bu[2] !== 4'd3) begin
          n_fail++;
          $display("FAIL bcd23: got %0d%0d, want 23", bt[2], bu[2]);
        end
      end
    end
    idle();
  endtask
  task automatic test_count_down();
    idle();
    cn[0] = 1'b1;
    up[0] = 1'b0;
    step_cycle();
    n_tests++;
    if (cnt[0] !== 7'd59 || co[0] !== 1'b1 || bt[0] !== 4'd5 || bu[0] !== 4'd9) begin
      n_fail++;
      $display("FAIL down60 wrap: got cnt=%0d co=%b bcd=%0d%0d, want 59 1 59", cnt[0], co[0], bt[0], bu[0]);
    end
    step_cycle();
    n_tests++;
    if (cnt[0] !== 7'd58 || co[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL down60 next: got cnt=%0d co=%b, want 58 0", cnt[0], co[0]);
    end
    idle();
  endtask
  task automatic test_load();
    idle();
    ld[2] = 1'b1;
    cn[2] = 1'b1;
    din[2] = 7'd30;
    step_cycle();
    n_tests++;
    if (cnt[2] !== 7'd0 || err[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL load30: got cnt=%0d err=%b, want 0 1", cnt[2], err[2]);
    end
    din[2] = 7'd17;
    step_cycle();
    n_tests++;
    if (cnt[2] !== 7'd17 || bt[2] !== 4'd1 || bu[2] !== 4'd7 || co[2] !== 1'b0 || err[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL load17: got cnt=%0d bcd=%0d%0d co=%b err=%b, want 17 17 0 0", cnt[2], bt[2], bu[2], co[2], err[2]);
    end
    idle();
  endtask
  task automatic test_saturate();
    idle();
    ld[3] = 1'b1;
    din[3] = 7'd11;
    step_cycle();
    ld[3] = 1'b0;
    cn[3] = 1'b1;
    #1;
    n_tests++;
    if (tc[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat tc@11: got %b, want 1", tc[3]);
    end
    step_cycle();
    n_tests++;
    if (cnt[3] !== 7'd11 || co[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat hold11: got cnt=%0d co=%b, want 11 0", cnt[3], co[3]);
    end
    ld[3] = 1'b1;
    din[3] = 7'd0;
    step_cycle();
    ld[3] = 1'b0;
    up[3] = 1'b0;
    #1;
    n_tests++;
    if (tc[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat tc@0: got %b, want 1", tc[3]);
    end
    step_cycle();
    n_tests++;
    if (cnt[3] !== 7'd0 || co[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat hold0: got cnt=%0d co=%b, want 0 0", cnt[3], co[3]);
    end
    idle();
  endtask
  task automatic test_cascade();
    idle();
    for (int i = 0; i < 3; i++) ld[i] = 1'b1;
    din[0] = 7'd59;
    din[1] = 7'd59;
    din[2] = 7'd23;
    step_cycle();
    chain = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld[i] = 1'b0;
      cn[i] = 1'b1;
    end
    #1;
    n_tests++;
    if (tc[0] !== 1'b1 || tc[1] !== 1'b1 || tc[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL cascade tc: got %b%b%b, want 111", tc[2], tc[1], tc[0]);
    end
    step_cycle();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (cnt[i] !== 7'd0 || co[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL cascade wrap[%0d]: got cnt=%0d co=%b, want 0 1", i, cnt[i], co[i]);
      end
    end
    step_cycle();
    n_tests++;
    if (cnt[0] !== 7'd1 || cnt[1] !== 7'd0 || cnt[2] !== 7'd0 || co[0] !== 1'b0 || co[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL cascade next: got %0d:%0d:%0d co=%b%b, want 0:0:1 00", cnt[2], cnt[1], cnt[0], co[1], co[0]);
    end
    idle();
  endtask
  task automatic test_priority();
    idle();
    ld[2] = 1'b1;
    din[2] = 7'd23;
    step_cycle();
    clr = 1'b0;
    cn[2] = 1'b1;
    din[2] = 7'd5;
    step_cycle();
    n_tests++;
    if (cnt[2] !== 7'd0 || co[2] !== 1'b0 || err[2] !== 1'b0 || bt[2] !== 4'd0 || bu[2] !== 4'd0) begin
      n_fail++;
      $display("FAIL clr priority: got cnt=%0d co=%b err=%b, want 0 0 0", cnt[2], co[2], err[2]);
    end
    clr = 1'b1;
    cn[2] = 1'b0;
    din[2] = 7'd23;
    step_cycle();
    en[2] = 1'b0;
    ld[2] = 1'b0;
    cn[2] = 1'b1;
    #1;
    n_tests++;
    if (tc[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled tc: got %b, want 0", tc[2]);
    end
    step_cycle();
    ld[2] = 1'b1;
    din[2] = 7'd3;
    step_cycle();
    n_tests++;
    if (cnt[2] !== 7'd23 || co[2] !== 1'b0 || err[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled hold: got cnt=%0d co=%b err=%b, want 23 0 0", cnt[2], co[2], err[2]);
    end
    idle();
  endtask
  task automatic test_random();
    idle();
    for (int k = 0; k < 800; k++) begin
      if (k % 40 == 0) chain = 1'($urandom_range(0, 1));
      clr = ($urandom % 64) != 0;
      for (int i = 0; i < 4; i++) begin
        en[i] = ($urandom % 8) != 0;
        ld[i] = ($urandom % 8) == 0;
        cn[i] = ($urandom % 4) != 0;
        up[i] = ($urandom % 3) != 0;
        din[i] = 7'($urandom % (1 << w[i]));
      end
      #1 predict();
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (tc[i] !== e_tc[i]) begin
          n_fail++;
          $display("FAIL rand tc[%0d] cyc %0d: got %b, want %b", i, k, tc[i], e_tc[i]);
        end
      end
      commit();
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (cnt[i] !== 7'(m_cnt[i]) || bt[i] !== 4'(m_cnt[i] / 10) || bu[i] !== 4'(m_cnt[i] % 10)
            || co[i] !== 1'(m_co[i]) || err[i] !== 1'(m_err[i])) begin
          n_fail++;
          $display("FAIL rand out[%0d] cyc %0d: got cnt=%0d bcd=%0d%0d co=%b err=%b, want %0d %0d %0d",
                   i, k, cnt[i], bt[i], bu[i], co[i], err[i], m_cnt[i], m_co[i], m_err[i]);
        end
      end
    end
    idle();
  endtask
  initial begin
    idle();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0;
      m_co[i] = 0;
      m_err[i] = 0;
      e_tc[i] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_saturate();
    test_cascade();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
